// File: rtl/mod_mul_serial.sv
// Serial modular multiplier: z = (a * b) mod MODULUS, one bit of a per clock,
// MSB first, using interleaved double / add / conditional-subtract steps.
// The multiplier comes from port b (B_MODE=0) or the constant B_CONST (B_MODE=1).
module mod_mul_serial #(
  parameter int MODULUS = 53,
  parameter int W       = 6,
  parameter int B_MODE  = 0,
  parameter int B_CONST = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         err
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0]    MOD_X    = (W+1)'(MODULUS);
  localparam logic [W-1:0]  BCONST_W = W'(B_CONST);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  // Reject parameter sets whose residues would not fit or whose constant is not reduced
  generate
    if (MODULUS < 2 || MODULUS >= (1 << W) || B_CONST < 0 || B_CONST >= MODULUS) begin : g_bad_params
      $error("mod_mul_serial: need 2 <= MODULUS < 2**W and 0 <= B_CONST < MODULUS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  acc;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  breg;
  logic [CW-1:0] cnt;
  logic [W-1:0]  b_sel;
  logic          range_fail;
  logic [W:0]    dbl;
  logic [W:0]    red1;
  logic [W:0]    sum;
  logic [W-1:0]  acc_nx;

  // Pick the multiplier source and flag operands that are not proper residues
  always_comb begin
    b_sel      = (B_MODE != 0) ? BCONST_W : b;
    range_fail = ({1'b0, a} >= MOD_X) || ((B_MODE == 0) && ({1'b0, b} >= MOD_X));
  end

  // One reduction stage: acc = (2*acc [+ breg]) mod M, each subtract applied at most once
  always_comb begin
    dbl    = {acc, 1'b0};
    red1   = (dbl >= MOD_X) ? (dbl - MOD_X) : dbl;
    sum    = a_sh[W-1] ? (red1 + {1'b0, breg}) : red1;
    acc_nx = (sum >= MOD_X) ? W'(sum - MOD_X) : sum[W-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; handshake outputs are pure functions of the state
  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid)      state_nx = RUN;
      RUN:     if (cnt == '0)     state_nx = DONE;
      DONE:    if (out_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, step one bit per RUN cycle, load the result on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      breg <= '0;
      cnt  <= '0;
      z    <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            breg <= b_sel;
            acc  <= '0;
            cnt  <= LAST_BIT;
            err  <= range_fail;
          end
        end
        RUN: begin
          acc  <= acc_nx;
          a_sh <= a_sh << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) z <= err ? '0 : acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mod_mul_serial.md
# mod_mul_serial

Parametrised sequential modular multiplier: computes z = (a × b) mod MODULUS for residues a, b < MODULUS, using one bit of a per clock (interleaved shift-add-reduce, MSB first). It generalises our fixed 6-bit mod-53 constant-multiply lookup blocks. The modulus and width are set by parameters, and the multiplier is either a runtime operand or a constant. It sits in the residue datapath behind a valid/ready handshake, so it can replace per-constant LUT instances where area matters more than throughput.

## Interface
- MODULUS, 53: modulus M. Requirement: 2 ≤ M < 2^W.
- W, 6: residue width in bits.
- B_MODE, 0: selects the multiplier source. 0 = use port b. 1 = use B_CONST, and port b is ignored.
- B_CONST, 30: constant multiplier used when B_MODE=1. Requirement: B_CONST < MODULUS.
- clk  in  1  single clock. All registers update on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands a/b are presented.
- in_ready  out  1  block can accept an operand pair (state IDLE).
- a  in  W  multiplicand residue.
- b  in  W  multiplier residue (B_MODE=0 only).
- out_valid  out  1  z/err hold a valid result.
- out_ready  in  1  consumer takes the result.
- z  out  W  result residue, always < MODULUS.
- err  out  1  an input was out of range (a ≥ M, or b ≥ M in B_MODE=0). When err=1, z=0.

## Operation
- States: IDLE, RUN, DONE.
- Reset values (asynchronous, take effect immediately): state=IDLE, in_ready=1, out_valid=0, z=0, err=0. Internal acc, a-shift register and bit counter are all 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a into the shift register, latch the multiplier (b or B_CONST) into breg, set acc=0, counter=W-1, err=range_fail. Go to RUN.
- RUN: each edge processes bit a[counter]:
  - t = 2·acc. If t ≥ M, t -= M.
  - If the bit is 1: t += breg. If t ≥ M, t -= M.
  - acc = t, then decrement counter.
  - On the edge where counter=0: go to DONE and load z = err ? 0 : t.
- Arithmetic width:
  - Intermediates are W+1 bits. Because both acc and breg are < M < 2^W, no value overflows W+1 bits.
  - Each conditional subtract is applied at most once per stage.
  - acc < M is invariant after every edge.
- DONE:
  - out_valid=1. z and err hold stable until the handshake.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. z and err keep their last value.
- in_ready is decoded from state: 1 only in IDLE. No new operand is accepted in the same cycle a result is consumed.
- An out-of-range input is not clipped. The computation still runs W cycles so latency stays constant, and the result is z=0, err=1.
- In B_MODE=1, port b is ignored and does not participate in the err check.
- Parameter legality (M < 2^W, B_CONST < M) is checked at elaboration. An illegal set is a compile-time error.

## Timing
- Accept at edge n.
- Bits are processed at edges n+1 … n+W.
- out_valid is high after edge n+W. Accept-to-result latency is W cycles.
- Earliest next accept is the edge after the out handshake, so the minimum initiation interval is W+2 cycles.
- Backpressure: out_valid stays high indefinitely while out_ready=0. in_ready stays 0 for that whole time.
- in_valid while not in IDLE is ignored. Operands must be re-presented.
- rst asserted mid-RUN or in DONE: the computation is aborted immediately and outputs go to their reset values. After deassertion, the first accept is possible at the next edge.
- out_ready while out_valid=0 has no effect.

## Test plan
- Default params (M=53, W=6), B_MODE=0, a=30, b=30 → out_valid exactly 6 cycles after accept, z=52, err=0. Then a=52, b=52 → z=1.
- a=0, b=41 → z=0. Then a=1, b=52 → z=52. Full sweep of all a, b < 53 against a reference model: every result matches and z < 53.
- a=53, b=5 → after 6 cycles z=0, err=1. Then a=5, b=60 → z=0, err=1.
- B_MODE=1, B_CONST=30: a=1 → z=30; a=2 → z=7; a=52 → z=23. b is driven with junk throughout, and err stays 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → z, err and out_valid stay stable and in_ready=0. Assert out_ready → in_ready=1 on the next cycle. rst pulsed 3 cycles into RUN → out_valid=0, z=0, in_ready=1 immediately. A subsequent operation is correct.
- MODULUS=251, W=8: a=250, b=250 → z=1 after 8 cycles. a=128, b=2 → z=5.
